// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the multi-cycle CPU.
//   Holds PC and IR, drives the instruction-memory address, slices IR into
//   decode fields and selects the next PC under controller control.
// Ports:
//   clk, Reset (sync, active-low)
//   PCWre, IRWre, InsMemRW, PCSrc[1:0]  controller strobes / next-PC select
//   rs_data[31:0]  jr target        ins_data[31:0]  instruction-memory read data
//   ins_addr, pc, pc_plus4, ir      32-bit PC/IR views
//   opcode, rs, rt, rd, sa, imm16   IR field slices
//   halted, align_err               sticky status flags
//   fetch_count[COUNT_W-1:0]        IR loads since reset (wraps)
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               PCWre,
  input  logic               IRWre,
  input  logic               InsMemRW,
  input  logic [1:0]         PCSrc,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        ins_data,
  output logic [31:0]        ins_addr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        ir,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         sa,
  output logic [15:0]        imm16,
  output logic               halted,
  output logic               align_err,
  output logic [COUNT_W-1:0] fetch_count
);

  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign ins_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sa       = ir[10:6];
  assign imm16    = ir[15:0];

  assign jr_misaligned = (PCSrc == 2'b10) && (rs_data[1:0] != 2'b00);

  // Next PC always derives from the current (old) ir, so a simultaneous
  // IR load does not affect the branch/jump target of this update.
  always_comb begin
    next_pc = pc_plus4;
    unique case (PCSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
      2'b10: next_pc = {rs_data[31:2], 2'b00};
      2'b11: next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc          <= PC_RESET;
      ir          <= 32'd0;
      halted      <= 1'b0;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else if (!halted) begin
      if (IRWre && InsMemRW) begin
        ir          <= ins_data;
        fetch_count <= fetch_count + COUNT_W'(1);
      end
      if (PCWre) begin
        pc <= next_pc;
        if (jr_misaligned) align_err <= 1'b1;
      end
      // Halt opcode already sitting in IR freezes the stage from next cycle on.
      if (ir[31:26] == 6'b111111) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          Reset, PCWre, IRWre, InsMemRW;
  logic [1:0]    PCSrc;
  logic [31:0]   rs_data, ins_data;
  logic [31:0]   ins_addr, pc, pc_plus4, ir;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, sa;
  logic [15:0]   imm16;
  logic          halted, align_err;
  logic [CW-1:0] fetch_count;

  int n_checks = 0;
  int n_err    = 0;

  // reference state
  logic [31:0] m_pc, m_ir;
  int          m_cnt;
  bit          m_halt, m_aerr;

  fetch_unit #(.PC_RESET(32'h0), .COUNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .PCSrc(PCSrc), .rs_data(rs_data), .ins_data(ins_data), .ins_addr(ins_addr),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .sa(sa), .imm16(imm16), .halted(halted), .align_err(align_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       pc,                        m_pc);
    chk({tag, ".ins_addr"}, ins_addr,                  m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4,                  m_pc + 32'd4);
    chk({tag, ".ir"},       ir,                        m_ir);
    chk({tag, ".opcode"},   32'(opcode),               m_ir / 32'h0400_0000);
    chk({tag, ".rs"},       32'(rs),                   (m_ir / 32'h20_0000) % 32);
    chk({tag, ".rt"},       32'(rt),                   (m_ir / 32'h1_0000) % 32);
    chk({tag, ".rd"},       32'(rd),                   (m_ir / 32'h800) % 32);
    chk({tag, ".sa"},       32'(sa),                   (m_ir / 32'h40) % 32);
    chk({tag, ".imm16"},    32'(imm16),                m_ir % 32'h1_0000);
    chk({tag, ".halted"},   32'(halted),               32'(m_halt));
    chk({tag, ".align"},    32'(align_err),            32'(m_aerr));
    chk({tag, ".count"},    32'(fetch_count),          32'(m_cnt));
  endtask

  // One clock: drive at negedge, advance the model, sample 1 time unit after posedge.
  task automatic step(input bit rst_n, input bit pcw, input bit irw, input bit mrw,
                      input logic [1:0] src, input logic [31:0] rsd, input logic [31:0] ins,
                      input string tag);
    logic [31:0] npc;
    int          off;
    @(negedge clk);
    Reset = rst_n; PCWre = pcw; IRWre = irw; InsMemRW = mrw;
    PCSrc = src; rs_data = rsd; ins_data = ins;
    if (!rst_n) begin
      m_pc = 32'h0; m_ir = 32'h0; m_cnt = 0; m_halt = 0; m_aerr = 0;
    end else if (!m_halt) begin
      off = int'($signed(m_ir[15:0])) * 4;
      case (src)
        2'd0: npc = m_pc + 4;
        2'd1: npc = m_pc + 4 + 32'(off);
        2'd2: npc = rsd - (rsd % 4);
        default: npc = ((m_pc + 4) & 32'hF000_0000) + (m_ir % 32'h0400_0000) * 4;
      endcase
      if (m_ir >= 32'hFC00_0000) m_halt = 1;
      if (irw && mrw) begin m_ir = ins; m_cnt = (m_cnt + 1) % (1 << CW); end
      if (pcw) begin
        m_pc = npc;
        if (src == 2'd2 && (rsd % 4) != 0) m_aerr = 1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [31:0] sv_pc, sv_ir, sv_cnt;

  initial begin
    Reset = 0; PCWre = 0; IRWre = 0; InsMemRW = 0; PCSrc = 0; rs_data = 0; ins_data = 0;
    m_pc = 0; m_ir = 0; m_cnt = 0; m_halt = 0; m_aerr = 0;

    // reset overrides simultaneous writes
    step(0, 1, 1, 1, 2'd0, 32'h0, 32'h1234_5678, "rst0");
    step(0, 1, 1, 1, 2'd0, 32'h0, 32'h1234_5678, "rst1");
    chk("rst.pc_const", pc, 32'h0);

    // sequential fetch
    step(1, 1, 1, 1, 2'd0, 32'h0, 32'h0000_0001, "seq1");
    step(1, 1, 1, 1, 2'd0, 32'h0, 32'h0000_0002, "seq2");
    step(1, 1, 1, 1, 2'd0, 32'h0, 32'h0000_0003, "seq3");
    chk("seq.pc_const", pc, 32'd12);
    chk("seq.ir_const", ir, 32'h3);
    chk("seq.cnt_const", 32'(fetch_count), 32'd3);

    // IRWre without InsMemRW holds ir/count
    step(1, 0, 1, 0, 2'd0, 32'h0, 32'hDEAD_BEEF, "irhold");

    // branch back to self (imm16 = -1)
    step(1, 1, 0, 0, 2'd2, 32'h10, 32'h0, "jr10");
    step(1, 0, 1, 1, 2'd0, 32'h0, 32'h0000_FFFF, "ldneg");
    step(1, 1, 0, 0, 2'd1, 32'h0, 32'h0, "brneg");
    chk("br.self", pc, 32'h10);
    step(1, 0, 1, 1, 2'd0, 32'h0, 32'h0000_0002, "ldpos");
    step(1, 1, 0, 0, 2'd1, 32'h0, 32'h0, "brpos");
    chk("br.fwd", pc, 32'h1C);

    // jump within region
    step(1, 1, 0, 0, 2'd2, 32'h1000_0040, 32'h0, "jrj");
    step(1, 0, 1, 1, 2'd0, 32'h0, 32'h0800_0010, "ldj");
    step(1, 1, 0, 0, 2'd3, 32'h0, 32'h0, "jmp");
    chk("jmp.pc", pc, 32'h1000_0040);

    // misaligned jr
    step(1, 1, 0, 0, 2'd2, 32'h23, 32'h0, "jrmis");
    chk("jrmis.pc", pc, 32'h20);
    chk("jrmis.align", 32'(align_err), 32'd1);

    // simultaneous PC/IR write: branch uses old ir (imm 2 from ldj? ir=0x08000010 -> imm 0x10)
    step(1, 1, 1, 1, 2'd1, 32'h0, 32'h0000_0100, "simul");

    // halt
    step(1, 0, 1, 1, 2'd0, 32'h0, 32'hFC00_0000, "ldhalt");
    step(1, 1, 1, 1, 2'd0, 32'h0, 32'h0000_0005, "halt");
    chk("halt.flag", 32'(halted), 32'd1);
    sv_pc = pc; sv_ir = ir; sv_cnt = 32'(fetch_count);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 1, 2'(i), 32'h44, 32'h0000_0007, "frozen");
      chk("frozen.pc", pc, sv_pc);
      chk("frozen.ir", ir, sv_ir);
      chk("frozen.cnt", 32'(fetch_count), sv_cnt);
    end
    step(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, "unhalt");
    chk("unhalt.flag", 32'(halted), 32'd0);

    // count wraps at 2^CW
    for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 2'd0, 32'h0, 32'(i), "wrap");
    chk("wrap.cnt", 32'(fetch_count), 32'd4);

    // mid-operation reset beats branch
    step(1, 1, 0, 0, 2'd0, 32'h0, 32'h0, "pre");
    step(0, 1, 0, 0, 2'd1, 32'h0, 32'h0, "midrst");
    chk("midrst.pc", pc, 32'h0);

    // randomized
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if (ins[31:26] == 6'h3F && $urandom_range(0, 3) != 0) ins[31] = 1'b0;
      step(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), $urandom, ins, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
